// File: rtl/dbg_pkg.sv
// Shared encodings for the debug controller: host opcodes, FSM states and
// default step timeout.
package dbg_pkg;
  localparam int STEP_TIMEOUT_DEF = 256;
  localparam int CNT_W            = 9;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_HALT    = 3'd1,
    OP_RESUME  = 3'd2,
    OP_STEP    = 3'd3,
    OP_RDREG   = 3'd4,
    OP_WRREG   = 3'd5,
    OP_RDPC    = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_HALTING   = 3'd1,
    ST_HALTED    = 3'd2,
    ST_STEPPING  = 3'd3,
    ST_STEPDRAIN = 3'd4,
    ST_READ      = 3'd5
  } state_e;
endpackage

// File: rtl/dbg_ctrl.sv
// Run-control debug unit: host command/response channel driving halt, resume,
// single-step and GPR/PC access on a simple in-order core.
module dbg_ctrl
  import dbg_pkg::*;
#(
  parameter int STEP_TIMEOUT  = STEP_TIMEOUT_DEF,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [4:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        core_run,
  input  logic        core_idle,
  input  logic        retire,
  input  logic        brk,
  input  logic [31:0] pc,
  output logic [4:0]  gpr_raddr,
  input  logic [31:0] gpr_rdata,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  output logic        gpr_wen,
  output logic        halted
);
  // Last STEPPING cycle index before timeout; clamps if the parameter exceeds the counter.
  localparam logic [CNT_W-1:0] TO_LIM = (STEP_TIMEOUT >= (1 << CNT_W)) ?
                                        {CNT_W{1'b1}} : CNT_W'(STEP_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [4:0]       raddr_q, raddr_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             wen_q, wen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_rsp_q, halt_rsp_d;
  logic             halt_err_q, halt_err_d;
  logic             accept;
  op_e              op;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = ((state_q == ST_RUN) || (state_q == ST_HALTED)) && !rsp_valid_q;
  assign accept    = cmd_valid && cmd_ready;

  assign core_run  = (state_q == ST_RUN) || (state_q == ST_STEPPING);
  assign halted    = (state_q == ST_HALTED);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign gpr_raddr = raddr_q;
  assign gpr_waddr = waddr_q;
  assign gpr_wdata = wdata_q;
  assign gpr_wen   = wen_q;

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    wen_d       = 1'b0;
    cnt_d       = cnt_q;
    halt_rsp_d  = halt_rsp_q;
    halt_err_d  = halt_err_q;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      ST_RUN: begin
        // A breakpoint halts silently; a host HALT in the same cycle overrides and owns the response.
        if (brk) begin
          state_d    = ST_HALTING;
          halt_rsp_d = 1'b0;
          halt_err_d = 1'b0;
        end
        if (accept) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
          case (op)
            OP_HALT: begin
              rsp_valid_d = 1'b0;
              state_d     = ST_HALTING;
              halt_rsp_d  = 1'b1;
              halt_err_d  = 1'b0;
            end
            OP_NOP, OP_RESUME: rsp_err_d = 1'b0;
            default:           rsp_err_d = 1'b1;
          endcase
        end
      end

      ST_HALTED: begin
        if (accept) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
          case (op)
            OP_RESUME: state_d = ST_RUN;
            OP_STEP: begin
              rsp_valid_d = 1'b0;
              state_d     = ST_STEPPING;
              cnt_d       = '0;
            end
            OP_RDREG: begin
              rsp_valid_d = 1'b0;
              raddr_d     = cmd_addr;
              state_d     = ST_READ;
            end
            OP_WRREG: begin
              waddr_d = cmd_addr;
              wdata_d = cmd_data;
              wen_d   = (cmd_addr != 5'd0);
            end
            OP_RDPC:    rsp_data_d = pc;
            OP_ILLEGAL: rsp_err_d  = 1'b1;
            default:    rsp_err_d  = 1'b0;
          endcase
        end
      end

      ST_READ: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = gpr_rdata;
        rsp_err_d   = 1'b0;
        state_d     = ST_HALTED;
      end

      ST_HALTING: begin
        if (core_idle) begin
          state_d = ST_HALTED;
          if (halt_rsp_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = pc;
            rsp_err_d   = halt_err_q;
          end
          halt_rsp_d = 1'b0;
          halt_err_d = 1'b0;
        end
      end

      ST_STEPPING: begin
        if (retire || brk) begin
          state_d = ST_STEPDRAIN;
        end else if (cnt_q >= TO_LIM) begin
          state_d    = ST_HALTING;
          halt_rsp_d = 1'b1;
          halt_err_d = 1'b1;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STEPDRAIN: begin
        if (core_idle) begin
          state_d     = ST_HALTED;
          rsp_valid_d = 1'b1;
          rsp_data_d  = pc;
          rsp_err_d   = 1'b0;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if (HALT_ON_RESET) state_q <= ST_HALTED;
      else               state_q <= ST_RUN;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      cnt_q       <= '0;
      halt_rsp_q  <= 1'b0;
      halt_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      cnt_q       <= cnt_d;
      halt_rsp_q  <= halt_rsp_d;
      halt_err_q  <= halt_err_d;
    end
  end
endmodule

// File: tb/tb_dbg_ctrl.sv
// Scenario bench for dbg_ctrl: expected responses are queued as commands are
// issued and popped when the DUT presents a response.
module tb_dbg_ctrl;
  import dbg_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        core_run, core_idle, retire, brk;
  logic [31:0] pc;
  logic [4:0]  gpr_raddr, gpr_waddr;
  logic [31:0] gpr_rdata, gpr_wdata;
  logic        gpr_wen, halted;

  logic [31:0] regs [32];
  int run_cnt = 0, wen_cnt = 0, rsp_cnt = 0;
  int n_checks = 0, n_fail = 0;
  exp_t sb[$];

  dbg_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_run(core_run), .core_idle(core_idle), .retire(retire), .brk(brk), .pc(pc),
    .gpr_raddr(gpr_raddr), .gpr_rdata(gpr_rdata), .gpr_waddr(gpr_waddr),
    .gpr_wdata(gpr_wdata), .gpr_wen(gpr_wen), .halted(halted)
  );

  always #5 clk = ~clk;

  assign gpr_rdata = regs[gpr_raddr];

  always @(posedge clk) begin
    if (core_run) run_cnt <= run_cnt + 1;
    if (gpr_wen) begin
      wen_cnt <= wen_cnt + 1;
      regs[gpr_waddr] <= gpr_wdata;
    end
    if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [4:0] addr, input logic [31:0] data);
    int w = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    while (!cmd_ready && w < 50) begin step(); w++; end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept: cmd_ready stayed 0 for op %0d, required 1", op);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input int max, output bit got, output int cyc, output exp_t e);
    cyc = 0;
    while (!rsp_valid && cyc < max) begin step(); cyc++; end
    got = rsp_valid;
    e.data = 'x; e.err = 'x;
    if (got && sb.size() > 0) e = sb.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b1; core_idle = 1'b1; retire = 1'b0; brk = 1'b0; pc = 32'h8000_0000;
    repeat (3) step();
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== 34'd0) begin
      n_fail++; $display("FAIL reset_rsp: valid=%b err=%b data=%h, required 0/0/0", rsp_valid, rsp_err, rsp_data);
    end
    n_checks++;
    if ({gpr_wen, gpr_raddr, gpr_waddr, gpr_wdata} !== 43'd0) begin
      n_fail++; $display("FAIL reset_gpr: wen=%b ra=%0d wa=%0d wd=%h, required all 0", gpr_wen, gpr_raddr, gpr_waddr, gpr_wdata);
    end
    n_checks++;
    if (core_run !== 1'b1 || halted !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: core_run=%b halted=%b, required 1/0", core_run, halted);
    end
    reset = 1'b1;
    step();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_run_cmds();
    logic [2:0] ops [7];
    logic       errs [7];
    bit got; int cyc; exp_t e;
    ops  = '{OP_NOP, OP_RESUME, OP_RDREG, OP_WRREG, OP_STEP, OP_RDPC, OP_ILLEGAL};
    errs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{32'd0, errs[i]});
      send_cmd(ops[i], 5'd3, 32'h1234_5678);
      n_checks++;
      if (gpr_wen !== 1'b0) begin
        n_fail++; $display("FAIL run_side_effect op%0d: gpr_wen=%b, required 0", ops[i], gpr_wen);
      end
      get_rsp(5, got, cyc, e);
      n_checks++;
      if (!got || cyc != 0) begin
        n_fail++; $display("FAIL run_lat op%0d: got=%b cyc=%0d, required 1/0", ops[i], got, cyc);
      end
      n_checks++;
      if (rsp_data !== e.data || rsp_err !== e.err) begin
        n_fail++; $display("FAIL run_rsp op%0d: data=%h err=%b, required %h/%b", ops[i], rsp_data, rsp_err, e.data, e.err);
      end
      step();
      n_checks++;
      if (core_run !== 1'b1 || halted !== 1'b0) begin
        n_fail++; $display("FAIL run_state op%0d: core_run=%b halted=%b, required 1/0", ops[i], core_run, halted);
      end
    end
  endtask

  task automatic test_halt();
    bit got; int cyc; exp_t e;
    pc = 32'h8000_0010; core_idle = 1'b0;
    sb.push_back('{32'h8000_0010, 1'b0});
    send_cmd(OP_HALT, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) core_idle = 1'b1;
      n_checks++;
      if (halted !== 1'b0 || core_run !== 1'b0 || rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL halting_%0d: halted=%b run=%b rsp_valid=%b, required 0/0/0", i, halted, core_run, rsp_valid);
      end
      if (i < 3) step();
    end
    get_rsp(5, got, cyc, e);
    n_checks++;
    if (!got || cyc != 1 || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_lat: got=%b cyc=%0d halted=%b, required 1/1/1", got, cyc, halted);
    end
    n_checks++;
    if (rsp_data !== e.data || rsp_err !== e.err) begin
      n_fail++; $display("FAIL halt_rsp: data=%h err=%b, required %h/%b", rsp_data, rsp_err, e.data, e.err);
    end
    step();
  endtask

  task automatic test_regs();
    bit got; int cyc; exp_t e; int w0;
    w0 = wen_cnt;
    sb.push_back('{32'd0, 1'b0});
    send_cmd(OP_WRREG, 5'd5, 32'hDEAD_BEEF);
    n_checks++;
    if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd5 || gpr_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL wr_port: wen=%b wa=%0d wd=%h, required 1/5/deadbeef", gpr_wen, gpr_waddr, gpr_wdata);
    end
    get_rsp(5, got, cyc, e);
    n_checks++;
    if (!got || cyc != 0 || rsp_data !== e.data || rsp_err !== e.err) begin
      n_fail++; $display("FAIL wr_rsp: got=%b cyc=%0d data=%h err=%b, required 1/0/%h/%b", got, cyc, rsp_data, rsp_err, e.data, e.err);
    end
    step();
    n_checks++;
    if (gpr_wen !== 1'b0 || wen_cnt - w0 != 1) begin
      n_fail++; $display("FAIL wr_pulse: wen=%b pulses=%0d, required 0/1", gpr_wen, wen_cnt - w0);
    end

    sb.push_back('{32'hDEAD_BEEF, 1'b0});
    send_cmd(OP_RDREG, 5'd5, 32'd0);
    n_checks++;
    if (gpr_raddr !== 5'd5 || halted !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_addr: raddr=%0d halted=%b rsp_valid=%b, required 5/0/0", gpr_raddr, halted, rsp_valid);
    end
    get_rsp(5, got, cyc, e);
    n_checks++;
    if (!got || cyc != 1 || rsp_data !== e.data || rsp_err !== e.err) begin
      n_fail++; $display("FAIL rd_rsp: got=%b cyc=%0d data=%h err=%b, required 1/1/%h/%b", got, cyc, rsp_data, rsp_err, e.data, e.err);
    end
    step();

    w0 = wen_cnt;
    sb.push_back('{32'd0, 1'b0});
    send_cmd(OP_WRREG, 5'd0, 32'h1234_5678);
    get_rsp(5, got, cyc, e);
    n_checks++;
    if (!got || rsp_data !== e.data || rsp_err !== e.err) begin
      n_fail++; $display("FAIL wr0_rsp: got=%b data=%h err=%b, required 1/%h/%b", got, rsp_data, rsp_err, e.data, e.err);
    end
    step(); step();
    n_checks++;
    if (wen_cnt != w0) begin
      n_fail++; $display("FAIL wr0_wen: pulses=%0d, required 0", wen_cnt - w0);
    end

    sb.push_back('{32'h8000_0010, 1'b0});
    send_cmd(OP_RDPC, 5'd0, 32'd0);
    get_rsp(5, got, cyc, e);
    n_checks++;
    if (!got || cyc != 0 || rsp_data !== e.data || rsp_err !== e.err) begin
      n_fail++; $display("FAIL rdpc_rsp: got=%b cyc=%0d data=%h err=%b, required 1/0/%h/%b", got, cyc, rsp_data, rsp_err, e.data, e.err);
    end
    step();
  endtask

  task automatic test_step();
    bit got; int cyc; exp_t e; int r0;
    core_idle = 1'b0; retire = 1'b0;
    r0 = run_cnt;
    sb.push_back('{32'h8000_0014, 1'b0});
    send_cmd(OP_STEP, 5'd0, 32'd0);
    step();
    retire = 1'b1; pc = 32'h8000_0014;
    step();
    retire = 1'b0; core_idle = 1'b1;
    get_rsp(10, got, cyc, e);
    n_checks++;
    if (!got || halted !== 1'b1 || run_cnt - r0 != 2) begin
      n_fail++; $display("FAIL step_run: got=%b halted=%b run_cycles=%0d, required 1/1/2", got, halted, run_cnt - r0);
    end
    n_checks++;
    if (rsp_data !== e.data || rsp_err !== e.err) begin
      n_fail++; $display("FAIL step_rsp: data=%h err=%b, required %h/%b", rsp_data, rsp_err, e.data, e.err);
    end
    step();

    r0 = run_cnt;
    sb.push_back('{32'h8000_0014, 1'b1});
    send_cmd(OP_STEP, 5'd0, 32'd0);
    get_rsp(400, got, cyc, e);
    n_checks++;
    if (!got || cyc != 257 || run_cnt - r0 != 256) begin
      n_fail++; $display("FAIL step_to_lat: got=%b cyc=%0d run_cycles=%0d, required 1/257/256", got, cyc, run_cnt - r0);
    end
    n_checks++;
    if (rsp_err !== e.err || halted !== 1'b1) begin
      n_fail++; $display("FAIL step_to_err: err=%b halted=%b, required %b/1", rsp_err, halted, e.err);
    end
    step();
  endtask

  task automatic test_brk();
    bit got; int cyc; exp_t e; int c0; bit seen;
    sb.push_back('{32'd0, 1'b0});
    send_cmd(OP_RESUME, 5'd0, 32'd0);
    get_rsp(5, got, cyc, e);
    n_checks++;
    if (!got || rsp_err !== e.err || core_run !== 1'b1) begin
      n_fail++; $display("FAIL resume: got=%b err=%b run=%b, required 1/%b/1", got, rsp_err, core_run, e.err);
    end
    step();
    core_idle = 1'b0; brk = 1'b1;
    c0 = rsp_cnt;
    step();
    brk = 1'b0;
    n_checks++;
    if (halted !== 1'b0 || core_run !== 1'b0) begin
      n_fail++; $display("FAIL brk_halting: halted=%b run=%b, required 0/0", halted, core_run);
    end
    core_idle = 1'b1;
    step();
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid) seen = 1'b1;
      step();
    end
    n_checks++;
    if (halted !== 1'b1 || seen || rsp_cnt != c0) begin
      n_fail++; $display("FAIL brk_silent: halted=%b rsp_seen=%b rsps=%0d, required 1/0/0", halted, seen, rsp_cnt - c0);
    end

    sb.push_back('{32'd0, 1'b0});
    send_cmd(OP_RESUME, 5'd0, 32'd0);
    get_rsp(5, got, cyc, e);
    step();
    core_idle = 1'b0;
    c0 = rsp_cnt;
    sb.push_back('{32'h8000_0014, 1'b0});
    brk = 1'b1;
    send_cmd(OP_HALT, 5'd0, 32'd0);
    brk = 1'b0; core_idle = 1'b1;
    get_rsp(5, got, cyc, e);
    n_checks++;
    if (!got || cyc != 1 || rsp_data !== e.data || rsp_err !== e.err) begin
      n_fail++; $display("FAIL brk_halt_rsp: got=%b cyc=%0d data=%h err=%b, required 1/1/%h/%b", got, cyc, rsp_data, rsp_err, e.data, e.err);
    end
    repeat (5) step();
    n_checks++;
    if (rsp_cnt - c0 != 1 || halted !== 1'b1) begin
      n_fail++; $display("FAIL brk_halt_once: rsps=%0d halted=%b, required 1/1", rsp_cnt - c0, halted);
    end
  endtask

  task automatic test_backpressure();
    bit got; int cyc; exp_t e; bit bad;
    rsp_ready = 1'b0;
    sb.push_back('{32'h8000_0014, 1'b0});
    send_cmd(OP_RDPC, 5'd0, 32'd0);
    get_rsp(5, got, cyc, e);
    bad = !got;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_err !== e.err || cmd_ready !== 1'b0) bad = 1'b1;
      pc = pc + 32'd4;
      step();
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL bp_stable: valid=%b data=%h err=%b ready=%b, required 1/%h/%b/0", rsp_valid, rsp_data, rsp_err, cmd_ready, e.data, e.err);
    end
    rsp_ready = 1'b1;
    step();
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: valid=%b cmd_ready=%b, required 0/1", rsp_valid, cmd_ready);
    end
    pc = 32'h8000_0014;
  endtask

  task automatic test_reset_mid();
    bit got; int cyc; exp_t e; bit seen;
    sb.push_back('{32'd0, 1'b0});
    send_cmd(OP_RESUME, 5'd0, 32'd0);
    get_rsp(5, got, cyc, e);
    step();
    core_idle = 1'b0;
    sb.push_back('{32'h8000_0014, 1'b0});
    send_cmd(OP_HALT, 5'd0, 32'd0);
    step();
    n_checks++;
    if (core_run !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL mid_halting: run=%b halted=%b, required 0/0", core_run, halted);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || core_run !== 1'b1 || halted !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: rsp_valid=%b run=%b halted=%b, required 0/1/0", rsp_valid, core_run, halted);
    end
    sb.delete();
    step(); step();
    reset = 1'b1;
    core_idle = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp_valid || halted) seen = 1'b1;
    end
    n_checks++;
    if (seen || core_run !== 1'b1) begin
      n_fail++; $display("FAIL mid_late_rsp: seen=%b run=%b, required 0/1", seen, core_run);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run_cmds();
    test_halt();
    test_regs();
    test_step();
    test_brk();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dbg_ctrl.md
DBG_CTRL -- requirements
Module: dbg_ctrl

Interface
REQ-001 SHALL have parameter STEP_TIMEOUT, default 256, meaning max cycles a STEP waits for a retire.
REQ-002 SHALL have parameter HALT_ON_RESET, default 0, meaning 1 = enter HALTED out of reset.
REQ-003 SHALL have port clk  in  1  the single clock; all logic on posedge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_op in 3, cmd_addr in 5, cmd_data in 32: the host command channel.
REQ-006 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out 32, rsp_err out 1: the host response channel.
REQ-007 SHALL have ports core_run out 1 (core may advance), core_idle in 1 (no instruction in flight), retire in 1 (one instruction retired this cycle), brk in 1 (ebreak retired), pc in 32.
REQ-008 SHALL have GPR ports gpr_raddr out 5, gpr_rdata in 32 (combinational read), gpr_waddr out 5, gpr_wdata out 32, gpr_wen out 1; and halted out 1.

Function
REQ-009 SHALL decode cmd_op as: 0 NOP, 1 HALT, 2 RESUME, 3 STEP, 4 RDREG, 5 WRREG, 6 RDPC, 7 illegal (rsp_err=1).
REQ-010 SHALL accept a command on a cycle where cmd_valid and cmd_ready are both 1.
REQ-011 SHALL drive cmd_ready=1 only in RUN or HALTED with no response pending.
REQ-012 SHALL hold rsp_valid, rsp_data and rsp_err stable until rsp_ready=1, then clear rsp_valid the next cycle.
REQ-013 SHALL implement states RUN, HALTING, HALTED, STEPPING, STEPDRAIN, READ.
REQ-014 SHALL drive core_run=1 in RUN and STEPPING only, and halted=1 in HALTED only.
REQ-015 SHALL handle HALT in RUN by going to HALTING; HALTING goes to HALTED on the first cycle core_idle=1, then responds with rsp_data=pc, rsp_err=0.
REQ-016 SHALL answer HALT in HALTED, and RESUME in RUN, in the cycle after accept with rsp_err=0 and no state change.
REQ-017 SHALL handle RESUME in HALTED by going to RUN and responding in the cycle after accept.
REQ-018 SHALL handle STEP in HALTED by going to STEPPING; on the first retire go to STEPDRAIN; on core_idle=1 go to HALTED and respond rsp_data=pc, rsp_err=0.
REQ-019 SHALL, when STEPPING reaches STEP_TIMEOUT cycles without a retire, go to HALTING and on reaching HALTED respond rsp_err=1; the cycle counter is 9 bits and saturates.
REQ-020 SHALL handle RDREG in HALTED as: cycle N accept, N+1 gpr_raddr=registered cmd_addr in state READ, N+2 rsp_valid with rsp_data=gpr_rdata sampled at N+1.
REQ-021 SHALL handle WRREG in HALTED by asserting gpr_wen for exactly cycle N+1 with registered addr/data, responding at N+1.
REQ-022 SHALL, for WRREG to addr 0, not assert gpr_wen, and respond rsp_err=0.
REQ-023 SHALL answer RDPC in HALTED at N+1 with rsp_data=pc.
REQ-024 SHALL answer RDREG, WRREG, RDPC or STEP outside HALTED at N+1 with rsp_err=1, rsp_data=0 and no side effect.
REQ-025 SHALL, on brk=1 in RUN, go to HALTING without generating a response, then set halted when core_idle=1.
REQ-026 SHALL, on brk=1 in STEPPING, treat the retire normally (brk implies retire); STEP completes with rsp_err=0.
REQ-027 SHALL give a simultaneous brk and host HALT one response only, from the HALT.
REQ-028 SHALL answer NOP at N+1 with rsp_err=0 and rsp_data=0.

Reset
REQ-029 SHALL, while reset=0, force state=RUN (HALTED if HALT_ON_RESET=1), rsp_valid=0, rsp_err=0, rsp_data=0, gpr_wen=0, gpr_raddr=0, gpr_waddr=0, gpr_wdata=0 and the timeout counter=0.
REQ-030 SHALL discard any in-progress command or pending response on reset assertion mid-operation, with no late response after release.

Structure
REQ-031 SHALL take the op encodings, state enum and STEP_TIMEOUT default from shared package dbg_pkg.
REQ-032 SHALL be a single flat module; no sub-module is needed.

Verification
REQ-033 SHALL cover: HALT with core_idle low 3 cycles -> halted at 4th, rsp_data=pc=0x80000010, err=0.
REQ-034 SHALL cover: halted, WRREG addr 5 data 0xDEADBEEF then RDREG 5 -> gpr_wen one cycle, read returns 0xDEADBEEF at N+2.
REQ-035 SHALL cover: WRREG addr 0 -> gpr_wen never 1; RDREG while running -> err=1.
REQ-036 SHALL cover: STEP with retire at cycle 2 -> core_run high exactly 2 cycles, rsp pc of next inst, err=0; STEP with no retire -> err=1 after 256 cycles.
REQ-037 SHALL cover: brk in RUN -> halted with no rsp; rsp_ready held 0 for 10 cycles -> rsp stable, cmd_ready=0.
REQ-038 SHALL cover: reset pulsed during HALTING -> RUN, rsp_valid=0, no late response.
